thermal_monitor: RTL and testbench
==================================

THERMAL_MONITOR -- requirements
Module: thermal_monitor

Interface
REQ-001 Parameter DATA_W, default 8, temperature sample width in bits.
REQ-002 Parameter HOT_TH, default 8'd90, threshold at or above which a sample counts as hot.
REQ-003 Parameter COOL_TH, default 8'd75, threshold at or below which a sample counts as cool.
REQ-004 Parameter N_CONSEC, default 4, number of consecutive qualifying samples needed for a state change.
REQ-005 Parameter TIMEOUT, default 1000, number of cycles without an accepted sample before a sensor fault is declared.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 areset_n  input  1  asynchronous, active-low reset.
REQ-008 temp_valid  input  1  sensor presents a sample.
REQ-009 temp_data  input  DATA_W  unsigned temperature sample.
REQ-010 temp_ready  output  1  monitor accepts a sample; a transfer occurs when temp_valid and temp_ready are both high.
REQ-011 fault_clear  input  1  single-cycle request to leave the sensor-fault state.
REQ-012 cpu_overheated  output  1  registered overheat flag, drives the downstream shut-off logic.
REQ-013 sensor_fault  output  1  registered watchdog fault flag.

Function
REQ-014 The FSM SHALL have the states NORMAL, WARM, OVERHEATED, COOLING and FAULT.
REQ-015 Sample classification SHALL be: hot when temp_data >= HOT_TH; cool when temp_data <= COOL_TH; otherwise mid.
REQ-016 NORMAL: a hot sample SHALL load the run counter with 1 and move to WARM, or go straight to OVERHEATED when N_CONSEC=1; other samples keep NORMAL.
REQ-017 WARM: each hot sample SHALL increment the run counter; the N_CONSEC-th consecutive hot sample SHALL move to OVERHEATED.
REQ-018 WARM: a mid or cool sample SHALL clear the run counter and return to NORMAL.
REQ-019 OVERHEATED: a cool sample SHALL load the run counter with 1 and move to COOLING; hot and mid samples keep OVERHEATED.
REQ-020 COOLING: each cool sample SHALL increment the run counter; the N_CONSEC-th consecutive cool sample SHALL move to NORMAL.
REQ-021 COOLING: a hot or mid sample SHALL clear the run counter and return to OVERHEATED.
REQ-022 cpu_overheated SHALL be high exactly in OVERHEATED, COOLING and FAULT, registered, rising or falling the cycle after the qualifying transfer.
REQ-023 The run counter SHALL be sized for N_CONSEC and SHALL never exceed it or wrap.
REQ-024 temp_ready SHALL be high in every state except FAULT.
REQ-025 The watchdog counter SHALL clear on every accepted transfer and otherwise increment, saturating at TIMEOUT.
REQ-026 When the watchdog counter reaches TIMEOUT in any non-FAULT state, the FSM SHALL enter FAULT with sensor_fault=1 and cpu_overheated=1 (fail-safe), the next cycle.
REQ-027 An accepted transfer in the same cycle the watchdog would expire SHALL win: the transfer is processed, the watchdog is cleared, and no fault is raised.
REQ-028 FAULT: temp_valid SHALL be ignored, and the watchdog SHALL be held at 0.
REQ-029 fault_clear in FAULT SHALL clear sensor_fault, clear the run counter, and move to OVERHEATED, so that N_CONSEC cool samples are required before release.
REQ-030 fault_clear outside FAULT SHALL have no effect.
REQ-031 Elaboration SHALL fail when HOT_TH <= COOL_TH, N_CONSEC < 1 or TIMEOUT < 2.

Reset
REQ-032 While areset_n=0, the block SHALL immediately force state=NORMAL, run counter=0, watchdog=0, cpu_overheated=0, sensor_fault=0 and temp_ready=1.
REQ-033 Reset asserted mid-sequence (WARM, COOLING or FAULT) SHALL discard all partial counts with no residual effect.
REQ-034 The first transfer SHALL be accepted on the first rising edge after areset_n deasserts.

Structure
REQ-035 A shared package SHALL hold the state enumeration and the default threshold, count and timeout constants.
REQ-036 A single sub-module, sat_counter (clear, enable, saturate at a parameter limit), SHALL be instanced twice: once as the run counter and once as the watchdog.

Verification
REQ-037 Hot streak: samples 95,95,95,95 on consecutive cycles -> cpu_overheated=1 the cycle after the 4th transfer, not before.
REQ-038 Broken streak: samples 95,95,95,80,95 -> cpu_overheated stays 0 and the state returns to NORMAL after the 80.
REQ-039 Hysteresis: from OVERHEATED, samples 75,75,80,75,75,75,75 -> stays high through the 80, falls after the last of four consecutive 75s.
REQ-040 Boundaries: a sample of exactly 90 counts as hot; a sample of exactly 75 counts as cool; 76 and 89 count as mid.
REQ-041 Watchdog: no transfer for 1000 cycles -> sensor_fault=1, cpu_overheated=1 and temp_ready=0; a transfer on the expiry cycle -> no fault; fault_clear followed by four 70s -> all outputs return to 0.
REQ-042 Reset mid-WARM after 3 hot samples: assert areset_n=0, then a single 95 -> stays NORMAL-side with cpu_overheated=0.

Source files
------------

// File: rtl/thermal_monitor_pkg.sv
// Shared types and default constants for the thermal monitor.
package thermal_monitor_pkg;

  typedef enum logic [2:0] {
    NORMAL,
    WARM,
    OVERHEATED,
    COOLING,
    FAULT
  } state_t;

  localparam logic [7:0]  DEF_HOT_TH   = 8'd90;
  localparam logic [7:0]  DEF_COOL_TH  = 8'd75;
  localparam int unsigned DEF_N_CONSEC = 4;
  localparam int unsigned DEF_TIMEOUT  = 1000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority) and enable, saturating at LIMIT.
module sat_counter #(
  parameter int unsigned LIMIT = 1,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/thermal_monitor.sv
// Hysteretic overheat detector with consecutive-sample qualification and a
// sensor watchdog that forces a fail-safe overheat indication.
module thermal_monitor
  import thermal_monitor_pkg::*;
#(
  parameter int unsigned        DATA_W   = 8,
  parameter logic [DATA_W-1:0]  HOT_TH   = DATA_W'(DEF_HOT_TH),
  parameter logic [DATA_W-1:0]  COOL_TH  = DATA_W'(DEF_COOL_TH),
  parameter int unsigned        N_CONSEC = DEF_N_CONSEC,
  parameter int unsigned        TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] temp_data,
  output logic              temp_ready,
  input  logic              fault_clear,
  output logic              cpu_overheated,
  output logic              sensor_fault
);

  if ((HOT_TH <= COOL_TH) || (N_CONSEC < 1) || (TIMEOUT < 2)) begin : g_param_check
    $error("thermal_monitor: need HOT_TH > COOL_TH, N_CONSEC >= 1, TIMEOUT >= 2");
  end

  localparam int unsigned RUN_W = $clog2(N_CONSEC + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  state_t           state, state_next;
  logic [RUN_W-1:0] run_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             run_clear, run_inc;
  logic             xfer, hot, cool, run_last, wd_expire;

  assign temp_ready = (state != FAULT);
  assign xfer       = temp_valid && temp_ready;
  assign hot        = (temp_data >= HOT_TH);
  assign cool       = (temp_data <= COOL_TH);
  assign run_last   = (run_cnt == RUN_W'(N_CONSEC - 1));
  // An accepted transfer on the expiry cycle pre-empts the fault.
  assign wd_expire  = (state != FAULT) && !xfer && (wd_cnt == WD_W'(TIMEOUT - 1));

  sat_counter #(.LIMIT(N_CONSEC), .W(RUN_W)) u_run_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (run_clear),
    .enable   (run_inc),
    .count    (run_cnt)
  );

  sat_counter #(.LIMIT(TIMEOUT), .W(WD_W)) u_watchdog (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (xfer || (state == FAULT)),
    .enable   (state != FAULT),
    .count    (wd_cnt)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state          <= NORMAL;
      cpu_overheated <= 1'b0;
      sensor_fault   <= 1'b0;
    end else begin
      state          <= state_next;
      cpu_overheated <= (state_next == OVERHEATED) || (state_next == COOLING) ||
                        (state_next == FAULT);
      sensor_fault   <= (state_next == FAULT);
    end
  end

  // The run counter is cleared on every entry to NORMAL/OVERHEATED, so a fresh
  // streak always starts from zero and the increment yields the "load 1".
  always_comb begin
    state_next = state;
    run_clear  = 1'b0;
    run_inc    = 1'b0;
    unique case (state)
      NORMAL: begin
        if (xfer && hot) begin
          if (N_CONSEC == 1) begin
            state_next = OVERHEATED;
          end else begin
            state_next = WARM;
            run_inc    = 1'b1;
          end
        end
      end
      WARM: begin
        if (xfer) begin
          if (!hot) begin
            state_next = NORMAL;
            run_clear  = 1'b1;
          end else if (run_last) begin
            state_next = OVERHEATED;
            run_clear  = 1'b1;
          end else begin
            run_inc = 1'b1;
          end
        end
      end
      OVERHEATED: begin
        if (xfer && cool) begin
          if (N_CONSEC == 1) begin
            state_next = NORMAL;
          end else begin
            state_next = COOLING;
            run_inc    = 1'b1;
          end
        end
      end
      COOLING: begin
        if (xfer) begin
          if (!cool) begin
            state_next = OVERHEATED;
            run_clear  = 1'b1;
          end else if (run_last) begin
            state_next = NORMAL;
            run_clear  = 1'b1;
          end else begin
            run_inc = 1'b1;
          end
        end
      end
      FAULT: begin
        run_clear = 1'b1;
        if (fault_clear) state_next = OVERHEATED;
      end
      default: begin
        state_next = NORMAL;
        run_clear  = 1'b1;
      end
    endcase
    if (wd_expire) begin
      state_next = FAULT;
      run_clear  = 1'b1;
    end
  end

endmodule

// File: tb/tb_thermal_monitor.sv
// Directed self-checking bench for thermal_monitor with default parameters.
module tb_thermal_monitor;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       temp_valid = 1'b0;
  logic [7:0] temp_data = '0;
  logic       fault_clear = 1'b0;
  logic       temp_ready, cpu_overheated, sensor_fault;

  int unsigned checks = 0;
  int unsigned failures = 0;

  thermal_monitor #(
    .DATA_W   (8),
    .HOT_TH   (8'd90),
    .COOL_TH  (8'd75),
    .N_CONSEC (4),
    .TIMEOUT  (1000)
  ) dut (
    .clk            (clk),
    .areset_n       (areset_n),
    .temp_valid     (temp_valid),
    .temp_data      (temp_data),
    .temp_ready     (temp_ready),
    .fault_clear    (fault_clear),
    .cpu_overheated (cpu_overheated),
    .sensor_fault   (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Outputs packed as {cpu_overheated, sensor_fault, temp_ready}.
  function automatic logic [2:0] outs();
    return {cpu_overheated, sensor_fault, temp_ready};
  endfunction

  // One sample presented for exactly one cycle; returns #1 after the edge.
  task automatic send(input logic [7:0] d);
    temp_valid = 1'b1;
    temp_data  = d;
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Async reset pulse between edges; outputs must change immediately.
  task automatic pulse_reset(input string tag);
    #1;
    areset_n = 1'b0;
    #1;
    check(tag, 32'(outs()), 32'b001);
    @(posedge clk);
    #1;
    areset_n = 1'b1;
  endtask

  initial begin
    // Reset state while areset_n is low from time zero.
    #2;
    check("reset_outs", 32'(outs()), 32'b001);
    @(posedge clk);
    #1;
    check("reset_hold", 32'(outs()), 32'b001);
    areset_n = 1'b1;

    // Hot streak, starting on the first edge after reset release.
    for (int i = 0; i < 3; i++) begin
      send(8'd95);
      check("hot_streak_pre", 32'(cpu_overheated), 32'd0);
    end
    send(8'd95);
    check("hot_streak_4th", 32'(outs()), 32'b101);

    // Hysteresis from OVERHEATED.
    send(8'd75); send(8'd75); send(8'd80);
    check("hyst_through_80", 32'(cpu_overheated), 32'd1);
    send(8'd75); send(8'd75); send(8'd75);
    check("hyst_three_cool", 32'(cpu_overheated), 32'd1);
    send(8'd75);
    check("hyst_release", 32'(outs()), 32'b001);

    // Broken streak: 80 returns to NORMAL; four fresh hots needed afterwards.
    send(8'd95); send(8'd95); send(8'd95); send(8'd80); send(8'd95);
    check("broken_streak", 32'(cpu_overheated), 32'd0);
    send(8'd95); send(8'd95);
    check("broken_restart3", 32'(cpu_overheated), 32'd0);
    send(8'd95);
    check("broken_restart4", 32'(cpu_overheated), 32'd1);
    for (int i = 0; i < 4; i++) send(8'd75);
    check("broken_cooldown", 32'(cpu_overheated), 32'd0);

    // Boundaries: 90 hot, 89 mid, 76 mid, 75 cool.
    for (int i = 0; i < 6; i++) send(8'd89);
    check("bnd_89_not_hot", 32'(cpu_overheated), 32'd0);
    send(8'd90); send(8'd90); send(8'd90); send(8'd76);
    send(8'd90); send(8'd90); send(8'd90);
    check("bnd_76_breaks_warm", 32'(cpu_overheated), 32'd0);
    send(8'd90);
    check("bnd_90_hot", 32'(cpu_overheated), 32'd1);
    send(8'd75); send(8'd75); send(8'd75); send(8'd89);
    send(8'd75); send(8'd75); send(8'd75);
    check("bnd_89_breaks_cool", 32'(cpu_overheated), 32'd1);
    send(8'd75);
    check("bnd_75_cool", 32'(cpu_overheated), 32'd0);

    // fault_clear outside FAULT does nothing (WARM must not jump ahead).
    send(8'd95); send(8'd95); send(8'd95);
    fault_clear = 1'b1;
    idle(1);
    fault_clear = 1'b0;
    check("fclr_noeffect", 32'(outs()), 32'b001);
    send(8'd95);
    check("fclr_streak_kept", 32'(cpu_overheated), 32'd1);

    // Reset mid-COOLING discards the partial cool count.
    send(8'd70); send(8'd70);
    pulse_reset("reset_mid_cooling");
    send(8'd70);
    check("after_reset_cooling", 32'(outs()), 32'b001);

    // Reset mid-WARM after three hots, then a single hot stays NORMAL-side.
    send(8'd95); send(8'd95); send(8'd95);
    pulse_reset("reset_mid_warm");
    send(8'd95);
    check("warm_reset_single", 32'(cpu_overheated), 32'd0);
    send(8'd95); send(8'd95);
    check("warm_reset_three", 32'(cpu_overheated), 32'd0);
    send(8'd95);
    check("warm_reset_four", 32'(cpu_overheated), 32'd1);

    // Watchdog: a transfer exactly on the expiry cycle wins.
    pulse_reset("reset_before_wd");
    idle(999);
    check("wd_999_no_fault", 32'(outs()), 32'b001);
    send(8'd95);
    check("wd_expiry_xfer_wins", 32'(outs()), 32'b001);

    // Watchdog: 1000 idle cycles (here in WARM) raise the fail-safe fault.
    idle(999);
    check("wd_pre_expire", 32'(outs()), 32'b001);
    idle(1);
    check("wd_fault", 32'(outs()), 32'b110);
    for (int i = 0; i < 5; i++) send(8'd70);
    check("fault_ignores_valid", 32'(outs()), 32'b110);
    idle(1500);
    check("fault_holds", 32'(outs()), 32'b110);

    // fault_clear -> OVERHEATED, then four cool samples release.
    fault_clear = 1'b1;
    idle(1);
    fault_clear = 1'b0;
    check("fclr_to_overheated", 32'(outs()), 32'b101);
    send(8'd70); send(8'd70); send(8'd70);
    check("fclr_three_cool", 32'(outs()), 32'b101);
    send(8'd70);
    check("fclr_release", 32'(outs()), 32'b001);

    // Reset while in FAULT.
    idle(1000);
    check("wd_fault_again", 32'(outs()), 32'b110);
    pulse_reset("reset_mid_fault");
    check("after_reset_fault", 32'(outs()), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
